// File: rtl/vending_ctrl_n.sv
// Multi-product vending controller: nickel/dime/quarter credit, common price,
// one-cycle dispense pulses and serial nickel change return.
module vending_ctrl_n #(
    parameter int NUM_ITEMS  = 2,
    parameter int PRICE      = 10,
    parameter int MAX_CREDIT = 20,
    parameter int CREDIT_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 nickel,
    input  logic                 dime,
    input  logic                 quarter,
    input  logic [NUM_ITEMS-1:0] select,
    input  logic                 cancel,
    output logic [NUM_ITEMS-1:0] give,
    output logic                 change_nickel,
    output logic                 coin_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy
);

    localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        VEND,
        CHANGE
    } state_t;

    state_t               r_state;
    logic                 r_nickel_q;
    logic                 r_dime_q;
    logic                 r_quarter_q;
    logic [IDX_W-1:0]     r_item;
    logic [CREDIT_W-1:0]  r_credit;
    logic [NUM_ITEMS-1:0] r_give;
    logic                 r_change;
    logic                 r_reject;
    logic                 r_busy;

    logic                 w_ev_n;
    logic                 w_ev_d;
    logic                 w_ev_q;
    logic [1:0]           w_num_ev;
    logic                 w_any_ev;
    logic [2:0]           w_coin_val;
    logic [CREDIT_W:0]    w_sum;
    logic                 w_fits;
    logic                 w_sel_ok;
    logic [IDX_W-1:0]     w_sel_idx;
    logic [NUM_ITEMS-1:0] w_item_oh;

    assign w_ev_n   = nickel & ~r_nickel_q;
    assign w_ev_d   = dime & ~r_dime_q;
    assign w_ev_q   = quarter & ~r_quarter_q;
    assign w_num_ev = {1'b0, w_ev_n} + {1'b0, w_ev_d} + {1'b0, w_ev_q};
    assign w_any_ev = w_ev_n | w_ev_d | w_ev_q;

    // Value only matters when exactly one coin event is present.
    assign w_coin_val = w_ev_q ? 3'd5 : (w_ev_d ? 3'd2 : (w_ev_n ? 3'd1 : 3'd0));

    // One extra bit so an overflowing coin cannot wrap the comparison.
    assign w_sum  = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
    assign w_fits = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    assign w_sel_ok = $onehot(select) && (r_credit >= CREDIT_W'(PRICE));

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (select[i]) w_sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_item_oh = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            w_item_oh[i] = (r_item == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_nickel_q  <= 1'b0;
            r_dime_q    <= 1'b0;
            r_quarter_q <= 1'b0;
            r_item      <= '0;
            r_credit    <= '0;
            r_give      <= '0;
            r_change    <= 1'b0;
            r_reject    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_nickel_q  <= nickel;
            r_dime_q    <= dime;
            r_quarter_q <= quarter;
            r_give      <= '0;
            r_change    <= 1'b0;
            r_reject    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (cancel && (r_credit != '0)) begin
                        r_state  <= CHANGE;
                        r_busy   <= 1'b1;
                        r_reject <= w_any_ev;
                    end else if (w_sel_ok) begin
                        r_credit <= r_credit - CREDIT_W'(PRICE);
                        r_item   <= w_sel_idx;
                        r_state  <= VEND;
                        r_busy   <= 1'b1;
                        r_reject <= w_any_ev;
                    end else if (w_num_ev == 2'd1) begin
                        if (w_fits) r_credit <= w_sum[CREDIT_W-1:0];
                        else        r_reject <= 1'b1;
                    end else if (w_any_ev) begin
                        r_reject <= 1'b1;
                    end
                end
                VEND: begin
                    r_give   <= w_item_oh;
                    r_reject <= w_any_ev;
                    if (r_credit != '0) begin
                        r_state <= CHANGE;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                CHANGE: begin
                    r_reject <= w_any_ev;
                    if (r_credit != '0) begin
                        r_change <= 1'b1;
                        r_credit <= r_credit - 1'b1;
                    end
                    // Last nickel leaves on the same edge credit hits zero.
                    if (r_credit <= CREDIT_W'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign give          = r_give;
    assign change_nickel = r_change;
    assign coin_reject   = r_reject;
    assign credit        = r_credit;
    assign busy          = r_busy;

endmodule

// File: tb/tb_vending_ctrl_n.sv
// Bench for vending_ctrl_n: directed test-plan steps, then random traffic,
// all checked against a schedule-based reference model.
module tb_vending_ctrl_n;

    localparam int PRICE      = 10;
    localparam int MAX_CREDIT = 20;

    logic       clk;
    logic       reset;
    logic       nickel;
    logic       dime;
    logic       quarter;
    logic [1:0] select;
    logic       cancel;
    logic [1:0] give;
    logic       change_nickel;
    logic       coin_reject;
    logic [5:0] credit;
    logic       busy;

    vending_ctrl_n dut (
        .clk          (clk),
        .reset        (reset),
        .nickel       (nickel),
        .dime         (dime),
        .quarter      (quarter),
        .select       (select),
        .cancel       (cancel),
        .give         (give),
        .change_nickel(change_nickel),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: credit plus a queue of scheduled future output cycles.
    typedef struct {
        logic [1:0] g;
        logic       c;
    } plan_t;

    plan_t      plan[$];
    int         m_credit;
    logic       m_pn, m_pd, m_pq;
    logic [1:0] m_give;
    logic       m_chg;
    logic       m_rej;

    int n_cmp;
    int n_fail;
    int t_g0, t_g1, t_chg, t_rej;
    string phase;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0d expected %0d",
                   phase, tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic n, input logic d, input logic q,
                              input logic [1:0] sel, input logic can,
                              input logic rst);
        int    nev;
        int    val;
        plan_t p;
        m_give = 2'b00;
        m_chg  = 1'b0;
        m_rej  = 1'b0;
        if (rst) begin
            m_credit = 0;
            plan.delete();
            m_pn = 1'b0;
            m_pd = 1'b0;
            m_pq = 1'b0;
            return;
        end
        nev = int'(n && !m_pn) + int'(d && !m_pd) + int'(q && !m_pq);
        val = (q && !m_pq) ? 5 : ((d && !m_pd) ? 2 : 1);
        if (plan.size() > 0) begin
            p = plan.pop_front();
            m_give = p.g;
            if (p.c) begin
                m_chg = 1'b1;
                m_credit--;
            end
            m_rej = (nev > 0);
        end else if (can && m_credit > 0) begin
            repeat (m_credit) plan.push_back('{2'b00, 1'b1});
            m_rej = (nev > 0);
        end else if ((sel == 2'b01 || sel == 2'b10) && m_credit >= PRICE) begin
            m_credit -= PRICE;
            plan.push_back('{sel, 1'b0});
            repeat (m_credit) plan.push_back('{2'b00, 1'b1});
            m_rej = (nev > 0);
        end else if (nev == 1) begin
            if (m_credit + val <= MAX_CREDIT) m_credit += val;
            else m_rej = 1'b1;
        end else if (nev > 1) begin
            m_rej = 1'b1;
        end
        m_pn = n;
        m_pd = d;
        m_pq = q;
    endtask

    task automatic cyc(input logic n, input logic d, input logic q,
                       input logic [1:0] sel, input logic can,
                       input logic rst);
        nickel  = n;
        dime    = d;
        quarter = q;
        select  = sel;
        cancel  = can;
        reset   = rst;
        @(posedge clk);
        model_edge(n, d, q, sel, can, rst);
        #1;
        chk("give", 32'(give), 32'(m_give));
        chk("change", 32'(change_nickel), 32'(m_chg));
        chk("reject", 32'(coin_reject), 32'(m_rej));
        chk("credit", 32'(credit), 32'(m_credit));
        chk("busy", 32'(busy), 32'(plan.size() > 0));
        t_g0  += int'(give[0]);
        t_g1  += int'(give[1]);
        t_chg += int'(change_nickel);
        t_rej += int'(coin_reject);
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic coin_q();
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic clr_tally();
        t_g0  = 0;
        t_g1  = 0;
        t_chg = 0;
        t_rej = 0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_credit = 0;
        m_pn = 1'b0;
        m_pd = 1'b0;
        m_pq = 1'b0;
        nickel = 1'b0;
        dime = 1'b0;
        quarter = 1'b0;
        select = 2'b00;
        cancel = 1'b0;
        reset = 1'b1;
        clr_tally();

        phase = "reset";
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("credit0", 32'(credit), 0);
        chk("busy0", 32'(busy), 0);
        idle(1);

        phase = "tp1";
        clr_tally();
        coin_q();
        chk("credit_5", 32'(credit), 5);
        coin_q();
        chk("credit_10", 32'(credit), 10);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        idle(4);
        chk("give0_cnt", 32'(t_g0), 1);
        chk("chg_cnt", 32'(t_chg), 0);
        chk("credit_end", 32'(credit), 0);
        chk("busy_end", 32'(busy), 0);

        phase = "tp2";
        clr_tally();
        repeat (3) coin_q();
        chk("credit_15", 32'(credit), 15);
        cyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        idle(9);
        chk("give1_cnt", 32'(t_g1), 1);
        chk("chg_cnt", 32'(t_chg), 5);
        chk("credit_end", 32'(credit), 0);

        phase = "tp3";
        clr_tally();
        coin_q();
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        idle(1);
        chk("credit_7", 32'(credit), 7);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(10);
        chk("chg_cnt", 32'(t_chg), 7);
        chk("give_cnt", 32'(t_g0 + t_g1), 0);

        phase = "tp4";
        clr_tally();
        repeat (4) coin_q();
        chk("credit_20", 32'(credit), 20);
        coin_q();
        chk("rej_cnt", 32'(t_rej), 1);
        chk("credit_20b", 32'(credit), 20);

        phase = "tp5";
        clr_tally();
        cyc(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        idle(2);
        chk("sel11_credit", 32'(credit), 20);
        chk("sel11_give", 32'(t_g0 + t_g1), 0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(22);
        chk("drain", 32'(t_chg), 20);
        clr_tally();
        cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        idle(1);
        chk("dual_rej", 32'(t_rej), 1);
        chk("dual_credit", 32'(credit), 0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        idle(1);
        chk("dime_held", 32'(credit), 2);

        phase = "tp6";
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        repeat (3) coin_q();
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("rst_give", 32'(give), 0);
        chk("rst_chg", 32'(change_nickel), 0);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_busy", 32'(busy), 0);
        coin_q();
        chk("post_q", 32'(credit), 5);

        phase = "rand";
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 5) == 0,
                ($urandom % 5) == 0,
                ($urandom % 4) == 0,
                2'($urandom % 4),
                ($urandom % 15) == 0,
                ($urandom % 150) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vending_ctrl_n.md
Name: vending_ctrl_n

Overview:
- Parametrised multi-product vending controller; successor to the two-product soda/diet machine.
- Accepts nickel/dime/quarter coins and holds credit in nickel units.
- Vends one of NUM_ITEMS products at a common price. Returns change or cancelled credit as a serial train of nickel pulses.
- Sits between the coin-acceptor/button front end and the dispenser/change-hopper drivers.

Parameters:
- NUM_ITEMS, 2, number of products; one select bit and one give bit per product.
- PRICE, 10, product price in nickels (10 = 50 cents); must be at least 1 and no greater than MAX_CREDIT.
- MAX_CREDIT, 20, maximum credit held, in nickels (20 = 1.00).
- CREDIT_W, 6, credit register width; must satisfy MAX_CREDIT + 5 < 2**CREDIT_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- nickel  input  1  coin level; one nickel per rising edge detected.
- dime  input  1  coin level; one dime per rising edge detected.
- quarter  input  1  coin level; one quarter per rising edge detected.
- select  input  NUM_ITEMS  product request, one-hot; bit i requests product i.
- cancel  input  1  return all credit.
- give  output  NUM_ITEMS  one-cycle dispense pulse for product i.
- change_nickel  output  1  high for one cycle per nickel of change returned.
- coin_reject  output  1  one-cycle pulse when a detected coin is refused.
- credit  output  CREDIT_W  current credit in nickels.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - credit = 0; give = 0; change_nickel = 0; coin_reject = 0; busy = 0.
  - Coin edge-detect registers are cleared to 0, so a coin held high through reset release counts once, on the first clock edge after reset.
  - Reset overrides every other input, including mid-VEND or mid-CHANGE; any remaining change is forfeited.
- Coin detection:
  - A coin event is the coin input high while its registered previous value is low.
  - A coin held high for k cycles counts once.
  - Coin values in nickels: nickel = 1, dime = 2, quarter = 5.
- States: IDLE, VEND, CHANGE. All outputs are registered.
- IDLE, evaluated in priority order each edge:
  - cancel and credit > 0: go to CHANGE.
  - cancel and credit = 0: no effect.
  - select exactly one-hot and credit >= PRICE: credit <= credit - PRICE; latch the item index; go to VEND.
  - select not one-hot, or credit < PRICE: select is ignored and has no side effect.
  - Exactly one coin event, and credit + value <= MAX_CREDIT: credit increases by value at that edge.
  - Two or more simultaneous coin events: all are rejected; coin_reject = 1 next cycle; credit unchanged.
  - Coin that would exceed MAX_CREDIT: rejected; coin_reject pulses; credit unchanged.
  - A coin event in the same cycle as an accepted select or cancel is rejected (coin_reject pulses).
- VEND:
  - give[item] = 1 for exactly one cycle.
  - Next state is CHANGE if credit > 0, otherwise IDLE.
- CHANGE:
  - Each cycle: change_nickel = 1 and credit decrements by 1.
  - Leave for IDLE on the edge where credit reaches 0, so the number of change pulses equals the credit on entry.
- Coins detected in VEND or CHANGE are rejected (coin_reject pulses). select and cancel are ignored while busy.
- Latency:
  - Coin edge sampled at edge N: credit updated at N.
  - Accepted select at edge N: give high in cycle N+1 to N+2.
  - First change_nickel pulse in the cycle after VEND.
- Arithmetic:
  - Unsigned, CREDIT_W bits.
  - The overflow check uses a CREDIT_W+1-bit sum.
  - credit never exceeds MAX_CREDIT and never wraps below 0.

Test Plan:
- Two quarter pulses, then select=01 → credit 5 then 10; give[0] high for one cycle; no change_nickel; credit 0; busy back to 0.
- Three quarters, then select=10 → credit 15; give[1] for one cycle; then exactly 5 consecutive change_nickel cycles; credit 0; state IDLE.
- Quarter then dime, then cancel → credit 7; 7 change_nickel pulses; give stays 0.
- Four quarters then a fifth quarter → credit 20; fifth quarter gives coin_reject for one cycle; credit stays 20.
- nickel and dime rising on the same edge → coin_reject; credit unchanged. Dime held high 3 cycles → credit +2 once. select=11 with credit 20 → ignored.
- Credit 15, select=01, reset asserted in the 2nd CHANGE cycle → next cycle all outputs 0, credit 0, IDLE. A quarter afterwards gives credit 5.
